// File: rtl/tt_um_serial_subtractor.sv
// Bit-serial 8-bit subtractor (A - B), LSB first, one bit per enabled clock.
// Compile-time option: define SUB_SAT_EN to clamp negative results to 0x00.
module tt_um_serial_subtractor (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ena,
  input  logic [7:0] ui_in,
  input  logic [7:0] uio_in,
  output logic [7:0] uo_out,
  output logic [7:0] uio_out,
  output logic [7:0] uio_oe
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] SHIFT = 2'd1;
  localparam logic [1:0] DONE  = 2'd2;

  logic [1:0] state;
  logic [7:0] a_q;
  logic [7:0] b_q;
  logic [7:0] part_q;
  logic [7:0] result_q;
  logic [2:0] cnt_q;
  logic       bor_q;
  logic       borrow_q;

  logic       load_a;
  logic       load_b;
  logic       start;
  logic       any_load;
  logic       a_bit;
  logic       b_bit;
  logic       d_bit;
  logic       bout;
  logic [7:0] commit_val;
  logic       unused_uio;

  assign load_a     = uio_in[0];
  assign load_b     = uio_in[1];
  assign start      = uio_in[2];
  assign any_load   = load_a | load_b;
  assign unused_uio = &{1'b0, uio_in[7:3]};

  // NOTE: every variable gets a default at the top of always_comb so no path
  // can leave it unassigned and infer a latch.
  always_comb begin
    a_bit      = a_q[cnt_q];
    b_bit      = b_q[cnt_q];
    d_bit      = a_bit ^ b_bit ^ bor_q;
    bout       = (~a_bit & b_bit) | (~(a_bit ^ b_bit) & bor_q);
    commit_val = {d_bit, part_q[6:0]};
`ifdef SUB_SAT_EN
    if (bout) commit_val = 8'h00;
`endif
  end

  // NOTE: all state, including the operand and result registers, is reset so
  // the outputs read zero the moment rst_n falls; sequential state uses <=.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      a_q      <= 8'h00;
      b_q      <= 8'h00;
      part_q   <= 8'h00;
      result_q <= 8'h00;
      cnt_q    <= 3'd0;
      bor_q    <= 1'b0;
      borrow_q <= 1'b0;
    end else if (ena) begin
      case (state)
        IDLE, DONE: begin
          if (any_load) begin
            if (load_a) a_q <= ui_in;
            if (load_b) b_q <= ui_in;
            state <= IDLE;
          end else if (start) begin
            cnt_q <= 3'd0;
            bor_q <= 1'b0;
            state <= SHIFT;
          end
        end
        SHIFT: begin
          part_q[cnt_q] <= d_bit;
          bor_q         <= bout;
          cnt_q         <= cnt_q + 3'd1;
          if (cnt_q == 3'd7) begin
            result_q <= commit_val;
            borrow_q <= bout;
            state    <= DONE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign uo_out  = result_q;
  assign uio_out = {borrow_q, (state == DONE), (state == SHIFT), 5'b0_0000};
  assign uio_oe  = 8'b1110_0000;

endmodule

// File: tb/tb_tt_um_serial_subtractor.sv
// Self-checking bench for tt_um_serial_subtractor: directed cases plus random
// operand/enable-gap runs compared against an arithmetic reference.
module tb_tt_um_serial_subtractor;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       ena;
  logic [7:0] ui_in;
  logic [7:0] uio_in;
  logic [7:0] uo_out;
  logic [7:0] uio_out;
  logic [7:0] uio_oe;

  int total = 0;
  int bad   = 0;

  logic [7:0] exp_uo  = 8'h00;
  logic       exp_bor = 1'b0;

  tt_um_serial_subtractor dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .ena    (ena),
    .ui_in  (ui_in),
    .uio_in (uio_in),
    .uo_out (uo_out),
    .uio_out(uio_out),
    .uio_oe (uio_oe)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s: got=%0h want=%0h", tag, got, want);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic load_ops(input logic [7:0] a, input logic [7:0] b);
    ui_in  = a;
    uio_in = 8'h01;
    step();
    check("load_done_clr", 32'(uio_out[6]), 0);
    check("load_busy", 32'(uio_out[5]), 0);
    ui_in  = b;
    uio_in = 8'h02;
    step();
    uio_in = 8'h00;
  endtask

  // Starts a run; ena is dropped for gap_len edges after gap_bit bits are done.
  task automatic run_op(input logic [7:0] a, input logic [7:0] b,
                        input int gap_bit, input int gap_len, input bit inject);
    int         n;
    logic [7:0] e_out;
    logic       e_bor;
    n     = 8 + gap_len;
    e_bor = (a < b);
    e_out = 8'(a - b);
`ifdef SUB_SAT_EN
    if (e_bor) e_out = 8'h00;
`endif
    uio_in = 8'h04;
    step();
    uio_in = 8'h00;
    for (int k = 1; k <= n; k++) begin
      ena = !(gap_len > 0 && k > gap_bit && k <= gap_bit + gap_len);
      if (inject && k == 2) begin
        ui_in  = 8'h80;
        uio_in = 8'h05;
      end else begin
        uio_in = 8'h00;
      end
      step();
      if (k < n) begin
        check("busy", 32'(uio_out[5]), 1);
        check("done_early", 32'(uio_out[6]), 0);
        check("uo_hold", 32'(uo_out), 32'(exp_uo));
        check("bor_hold", 32'(uio_out[7]), 32'(exp_bor));
      end
    end
    ena    = 1'b1;
    uio_in = 8'h00;
    check("done", 32'(uio_out[6]), 1);
    check("busy_end", 32'(uio_out[5]), 0);
    check("result", 32'(uo_out), 32'(e_out));
    check("borrow", 32'(uio_out[7]), 32'(e_bor));
    check("low_bits", 32'(uio_out[4:0]), 0);
    exp_uo  = e_out;
    exp_bor = e_bor;
  endtask

  initial begin
    rst_n  = 1'b0;
    ena    = 1'b1;
    ui_in  = 8'h00;
    uio_in = 8'h00;
    #12;
    check("rst_uo", 32'(uo_out), 0);
    check("rst_uio", 32'(uio_out), 0);
    check("oe", 32'(uio_oe), 32'h0000_00E0);
    step();
    rst_n = 1'b1;
    step();

    // Basic subtraction, borrow cases, equal operands.
    load_ops(8'h35, 8'h12); run_op(8'h35, 8'h12, 0, 0, 1'b0);
    load_ops(8'h10, 8'h20); run_op(8'h10, 8'h20, 0, 0, 1'b0);
    load_ops(8'h00, 8'h01); run_op(8'h00, 8'h01, 0, 0, 1'b0);
    load_ops(8'hFF, 8'hFF); run_op(8'hFF, 8'hFF, 0, 0, 1'b0);

    // Loads and start during SHIFT must not disturb the run.
    load_ops(8'h35, 8'h12); run_op(8'h35, 8'h12, 0, 0, 1'b1);
    // Restart from DONE without reloading: operands must still be 0x35/0x12.
    run_op(8'h35, 8'h12, 0, 0, 1'b0);

    // ena low in DONE holds everything, including done.
    ena    = 1'b0;
    ui_in  = 8'h99;
    uio_in = 8'h05;
    step();
    check("ena_hold_done", 32'(uio_out[6]), 1);
    ena    = 1'b1;
    uio_in = 8'h00;

    // Enable gap of 3 cycles at bit 4: done 11 edges after start.
    run_op(8'h35, 8'h12, 4, 3, 1'b0);

    // Same byte to both operands via a combined load.
    ui_in  = 8'h5A;
    uio_in = 8'h03;
    step();
    uio_in = 8'h00;
    run_op(8'h5A, 8'h5A, 0, 0, 1'b0);

    // Load and start together: load wins, FSM stays out of SHIFT.
    ui_in  = 8'h40;
    uio_in = 8'h05;
    step();
    uio_in = 8'h00;
    check("load_beats_start", 32'(uio_out[5]), 0);
    run_op(8'h40, 8'h5A, 0, 0, 1'b0);

    // Reset in mid-SHIFT: asynchronous clear, no partial result.
    load_ops(8'h35, 8'h12); run_op(8'h35, 8'h12, 0, 0, 1'b0);
    load_ops(8'h10, 8'h20);
    uio_in = 8'h04;
    step();
    uio_in = 8'h00;
    repeat (3) step();
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_uo", 32'(uo_out), 0);
    check("arst_uio", 32'(uio_out), 0);
    exp_uo  = 8'h00;
    exp_bor = 1'b0;
    step();
    step();
    rst_n = 1'b1;
    check("post_rst_uo", 32'(uo_out), 0);
    load_ops(8'h35, 8'h12); run_op(8'h35, 8'h12, 0, 0, 1'b0);

    // Randomized operands, gaps and SHIFT-time interference.
    for (int i = 0; i < 40; i++) begin
      logic [7:0] ra;
      logic [7:0] rb;
      ra = 8'($urandom_range(0, 255));
      rb = 8'($urandom_range(0, 255));
      load_ops(ra, rb);
      run_op(ra, rb, int'($urandom_range(0, 7)), int'($urandom_range(0, 4)),
             1'($urandom_range(0, 1)));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
